// File: rtl/commit_if.sv
// Commit-stage handshake bundle: ROB head view, stall/ack inputs, and the
// register-file, map-table and store-request outputs of the commit stage.
interface commit_if #(
   parameter int XLEN        = 32,
   parameter int ROB_TAG_LEN = 2
);
   logic                   head_valid;
   logic                   head_ready;
   logic                   head_wr_mem;
   logic [4:0]             head_dest_reg;
   logic [XLEN-1:0]        head_value;
   logic [XLEN-1:0]        head_dest_addr;
   logic [ROB_TAG_LEN-1:0] head_tag;
   logic                   commit_stall;
   logic                   mem_st_ack;

   logic                   retire;
   logic                   rf_wr_en;
   logic [4:0]             rf_wr_idx;
   logic [XLEN-1:0]        rf_wr_data;
   logic                   mt_clr_en;
   logic [4:0]             mt_clr_reg;
   logic [ROB_TAG_LEN-1:0] mt_clr_tag;
   logic                   mem_st_req;
   logic [XLEN-1:0]        mem_st_addr;
   logic [XLEN-1:0]        mem_st_data;

   // Environment side: ROB, stall source and memory drive the stage.
   modport master (
      output head_valid, head_ready, head_wr_mem, head_dest_reg, head_value,
             head_dest_addr, head_tag, commit_stall, mem_st_ack,
      input  retire, rf_wr_en, rf_wr_idx, rf_wr_data, mt_clr_en, mt_clr_reg,
             mt_clr_tag, mem_st_req, mem_st_addr, mem_st_data
   );

   // Commit-stage side.
   modport slave (
      input  head_valid, head_ready, head_wr_mem, head_dest_reg, head_value,
             head_dest_addr, head_tag, commit_stall, mem_st_ack,
      output retire, rf_wr_en, rf_wr_idx, rf_wr_data, mt_clr_en, mt_clr_reg,
             mt_clr_tag, mem_st_req, mem_st_addr, mem_st_data
   );
endinterface

// File: rtl/commit_stage.sv
// In-order commit stage: zero-latency ALU retire, registered store request
// with ack wait. Optional statistics counters under COMMIT_STATS_EN.
module commit_stage #(
   parameter int XLEN        = 32,
   parameter int ROB_TAG_LEN = 2
) (
   input  logic        clock,
   input  logic        reset,
`ifdef COMMIT_STATS_EN
   output logic [31:0] retired_count,
   output logic [31:0] store_count,
`endif
   commit_if.slave     cif
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;

   logic                   head_go_s;
   logic                   st_start_s;
   logic                   st_done_s;
   logic                   retire_s;
   logic                   rf_wr_en_s;
   logic [4:0]             rf_wr_idx_s;
   logic [XLEN-1:0]        rf_wr_data_s;
   logic                   mt_clr_en_s;
   logic [4:0]             mt_clr_reg_s;
   logic [ROB_TAG_LEN-1:0] mt_clr_tag_s;

   logic                   mem_st_req_r;
   logic [XLEN-1:0]        mem_st_addr_r;
   logic [XLEN-1:0]        mem_st_data_r;

   assign head_go_s = cif.head_valid & cif.head_ready & ~cif.commit_stall;

   // Next-state and combinational commit outputs; all forced low under reset.
   always_comb begin
      state_nxt_s  = state_r;
      st_start_s   = 1'b0;
      st_done_s    = 1'b0;
      retire_s     = 1'b0;
      rf_wr_en_s   = 1'b0;
      rf_wr_idx_s  = 5'd0;
      rf_wr_data_s = {XLEN{1'b0}};
      mt_clr_en_s  = 1'b0;
      mt_clr_reg_s = 5'd0;
      mt_clr_tag_s = {ROB_TAG_LEN{1'b0}};
      if (reset) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (head_go_s && cif.head_wr_mem) begin
                  st_start_s  = 1'b1;
                  state_nxt_s = ST_WAIT;
               end else if (head_go_s) begin
                  retire_s = 1'b1;
                  // x0 is hardwired: no RF write and no map-table clear.
                  if (cif.head_dest_reg != 5'd0) begin
                     rf_wr_en_s   = 1'b1;
                     rf_wr_idx_s  = cif.head_dest_reg;
                     rf_wr_data_s = cif.head_value;
                     mt_clr_en_s  = 1'b1;
                     mt_clr_reg_s = cif.head_dest_reg;
                     mt_clr_tag_s = cif.head_tag;
                  end else begin
                     rf_wr_en_s  = 1'b0;
                     mt_clr_en_s = 1'b0;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            ST_WAIT: begin
               // Stall is deliberately ignored here: an issued store must finish.
               if (cif.mem_st_ack) begin
                  st_done_s   = 1'b1;
                  retire_s    = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Store request register: raised on store start, held until acked.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_st_req_r  <= 1'b0;
         mem_st_addr_r <= {XLEN{1'b0}};
         mem_st_data_r <= {XLEN{1'b0}};
      end else if (st_start_s) begin
         mem_st_req_r  <= 1'b1;
         mem_st_addr_r <= cif.head_dest_addr;
         mem_st_data_r <= cif.head_value;
      end else if (st_done_s) begin
         mem_st_req_r  <= 1'b0;
      end else begin
         mem_st_req_r  <= mem_st_req_r;
      end
   end

`ifdef COMMIT_STATS_EN
   logic [31:0] retired_count_r;
   logic [31:0] store_count_r;

   // Free-running commit statistics, wrapping at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         retired_count_r <= 32'd0;
         store_count_r   <= 32'd0;
      end else begin
         if (retire_s) begin
            retired_count_r <= retired_count_r + 32'd1;
         end else begin
            retired_count_r <= retired_count_r;
         end
         if (st_done_s) begin
            store_count_r <= store_count_r + 32'd1;
         end else begin
            store_count_r <= store_count_r;
         end
      end
   end

   assign retired_count = retired_count_r;
   assign store_count   = store_count_r;
`endif

   assign cif.retire      = retire_s;
   assign cif.rf_wr_en    = rf_wr_en_s;
   assign cif.rf_wr_idx   = rf_wr_idx_s;
   assign cif.rf_wr_data  = rf_wr_data_s;
   assign cif.mt_clr_en   = mt_clr_en_s;
   assign cif.mt_clr_reg  = mt_clr_reg_s;
   assign cif.mt_clr_tag  = mt_clr_tag_s;
   assign cif.mem_st_req  = mem_st_req_r;
   assign cif.mem_st_addr = mem_st_addr_r;
   assign cif.mem_st_data = mem_st_data_r;

endmodule

// File: tb/tb_commit_stage.sv
// Randomized and directed bench for commit_stage against a transaction-level
// model of the commit rules (pending-store record plus retire counters).
module tb_commit_stage;
   localparam int XLEN = 32;
   localparam int TW   = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   commit_if #(.XLEN(XLEN), .ROB_TAG_LEN(TW)) bus ();

`ifdef COMMIT_STATS_EN
   logic [31:0] retired_count;
   logic [31:0] store_count;
   commit_stage #(.XLEN(XLEN), .ROB_TAG_LEN(TW)) dut (
      .clock(clock), .reset(reset),
      .retired_count(retired_count), .store_count(store_count),
      .cif(bus.slave));
`else
   commit_stage #(.XLEN(XLEN), .ROB_TAG_LEN(TW)) dut (
      .clock(clock), .reset(reset), .cif(bus.slave));
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: an outstanding store (if any) plus retire tallies.
   bit              m_pend;
   logic [XLEN-1:0] m_addr, m_data;
   logic [31:0]     m_retired, m_stores;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
   task automatic step(input logic v, input logic r, input logic w, input logic [4:0] d,
                       input logic [XLEN-1:0] val, input logic [XLEN-1:0] addr,
                       input logic [TW-1:0] tag, input logic stall, input logic ack,
                       input logic rst);
      logic alu_ok, st_ok, e_ret, e_wr;
      @(posedge clock);
      #1;
      reset                  = rst;
      bus.head_valid         = v;
      bus.head_ready         = r;
      bus.head_wr_mem        = w;
      bus.head_dest_reg      = d;
      bus.head_value         = val;
      bus.head_dest_addr     = addr;
      bus.head_tag           = tag;
      bus.commit_stall       = stall;
      bus.mem_st_ack         = ack;
      #3;
      alu_ok = !rst && !m_pend && v && r && !stall && !w;
      st_ok  = !rst && !m_pend && v && r && !stall && w;
      e_ret  = rst ? 1'b0 : (m_pend ? ack : alu_ok);
      e_wr   = alu_ok && (d != 5'd0);
      chk("retire", bus.retire, e_ret);
      chk("rf_wr_en", bus.rf_wr_en, e_wr);
      chk("mt_clr_en", bus.mt_clr_en, e_wr);
      if (e_wr) begin
         chk("rf_wr_idx", bus.rf_wr_idx, d);
         chk("rf_wr_data", bus.rf_wr_data, val);
         chk("mt_clr_reg", bus.mt_clr_reg, d);
         chk("mt_clr_tag", bus.mt_clr_tag, tag);
      end
      chk("mem_st_req", bus.mem_st_req, m_pend);
      chk("mem_st_addr", bus.mem_st_addr, m_addr);
      chk("mem_st_data", bus.mem_st_data, m_data);
`ifdef COMMIT_STATS_EN
      chk("retired_count", retired_count, m_retired);
      chk("store_count", store_count, m_stores);
`endif
      if (rst) begin
         m_pend = 1'b0; m_addr = '0; m_data = '0;
         m_retired = 32'd0; m_stores = 32'd0;
      end else begin
         if (e_ret) m_retired = m_retired + 32'd1;
         if (m_pend && ack) begin
            m_pend = 1'b0;
            m_stores = m_stores + 32'd1;
         end else if (st_ok) begin
            m_pend = 1'b1; m_addr = addr; m_data = val;
         end
      end
   endtask

   task automatic idle(input logic ack);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0, ack, 1'b0);
   endtask

   initial begin
      m_pend = 1'b0; m_addr = '0; m_data = '0; m_retired = 32'd0; m_stores = 32'd0;
      // Reset, with a ready ALU head and a stray ack that must both be ignored.
      step(1'b1, 1'b1, 1'b0, 5'd3, 32'h1234, 32'h0, 2'd1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 5'd3, 32'h1234, 32'h40, 2'd1, 1'b0, 1'b1, 1'b1);
      chk("rst_retire", bus.retire, 1'b0);
      chk("rst_req", bus.mem_st_req, 1'b0);

      // ALU commit to x5.
      step(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
      chk("alu_retire", bus.retire, 1'b1);
      chk("alu_data", bus.rf_wr_data, 32'hDEAD_BEEF);
      chk("alu_tag", bus.mt_clr_tag, 2'd2);

      // Commit to x0: retire only.
      step(1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0, 2'd3, 1'b0, 1'b0, 1'b0);
      chk("x0_retire", bus.retire, 1'b1);
      chk("x0_wr", bus.rf_wr_en, 1'b0);

      // Store, acked on the third request-high cycle.
      step(1'b1, 1'b1, 1'b1, 5'd9, 32'h55, 32'h100, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("st_start_retire", bus.retire, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'd4, 32'h9, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'd4, 32'h9, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("st_wait_no_retire", bus.retire, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'd4, 32'h9, 32'h0, 2'd1, 1'b0, 1'b1, 1'b0);
      chk("st_ack_retire", bus.retire, 1'b1);
      chk("st_ack_no_wr", bus.rf_wr_en, 1'b0);
      chk("st_addr", bus.mem_st_addr, 32'h100);
      idle(1'b0);
      chk("st_req_drop", bus.mem_st_req, 1'b0);

      // Stall holds a ready ALU head for 4 cycles.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 1'b0, 5'd7, 32'hA5, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'd7, 32'hA5, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("unstall_retire", bus.retire, 1'b1);

      // Reset mid ST_WAIT, then a late ack.
      step(1'b1, 1'b1, 1'b1, 5'd1, 32'hCC, 32'h200, 2'd0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      chk("late_ack_retire", bus.retire, 1'b0);
      chk("late_ack_req", bus.mem_st_req, 1'b0);

`ifdef COMMIT_STATS_EN
      // Three ALU and two store commits from a fresh reset.
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b0, 5'(i + 1), 32'(i), 32'h0, 2'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 5'd2, 32'h10, 32'h300, 2'd0, 1'b0, 1'b0, 1'b0);
         idle(1'b1);
      end
      idle(1'b0);
      chk("stat_retired", retired_count, 32'd5);
      chk("stat_stores", store_count, 32'd2);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
              32'($urandom), 32'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 59) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
